// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data memory controller and its RAM bench.
// Holds FSM state encodings, access-size codes and the RAM geometry.
package data_mem_ctrl_pkg;

  localparam int MEM_DEPTH = 512;
  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    PRELOAD = 2'd0,
    IDLE    = 2'd1,
    ACCESS  = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_t;

  typedef struct packed {
    logic              rw;
    logic [1:0]        size;
    logic              se;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/data_mem_ctrl_align_chk.sv
// Combinational alignment check for a memory request.
// Only the two low address bits matter; the reserved size code always faults.
module mem_align_chk
  import data_mem_ctrl_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic       misalign
);

  always_comb begin
    misalign = 1'b0;
    case (size)
      SIZE_BYTE: misalign = 1'b0;
      SIZE_HALF: misalign = addr[0];
      SIZE_WORD: misalign = |addr;
      default:   misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: preloads the RAM byte by byte, then serves one
// pipeline load/store at a time with a registered single-cycle response.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              load_done,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_misalign,
  output logic              mem_enable,
  output logic              mem_rw,
  output logic [1:0]        mem_size,
  output logic              mem_se,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ld_cnt;
  mem_req_t          req_q;
  logic              mis_q;
  logic [DATA_W-1:0] rdata_q;
  logic              req_mis;
  logic              ld_fire, ld_final, req_fire;

  mem_align_chk u_align (
    .size     (req_size),
    .addr     (req_addr[1:0]),
    .misalign (req_mis)
  );

  // The last RAM location ends the preload even without ld_last.
  always_comb begin
    ld_fire  = (state == PRELOAD) && ld_valid && !reset;
    ld_final = ld_fire && (ld_last || (ld_cnt == ADDR_W'(MEM_DEPTH - 1)));
    req_fire = (state == IDLE) && req_valid && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= PRELOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PRELOAD: if (ld_final) state_nxt = IDLE;
      IDLE:    if (req_fire) state_nxt = req_mis ? RESP : ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = PRELOAD;
    endcase
  end

  // Misaligned requests clear the capture register at acceptance so they respond with 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_cnt    <= '0;
      load_done <= 1'b0;
      req_q     <= '0;
      mis_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (ld_fire)  ld_cnt    <= ld_cnt + ADDR_W'(1);
      if (ld_final) load_done <= 1'b1;
      if (req_fire) begin
        req_q   <= '{rw: req_rw, size: req_size, se: req_se,
                     addr: req_addr, wdata: req_wdata};
        mis_q   <= req_mis;
        rdata_q <= '0;
      end
      if (state == ACCESS) rdata_q <= req_q.rw ? mem_dout : '0;
    end
  end

  // Outputs are gated by reset so nothing is strobed during the reset cycle.
  always_comb begin
    ld_ready     = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_misalign = 1'b0;
    rsp_rdata    = '0;
    mem_enable   = 1'b0;
    mem_rw       = 1'b0;
    mem_size     = 2'b00;
    mem_se       = 1'b0;
    mem_addr     = '0;
    mem_din      = '0;
    if (!reset) begin
      case (state)
        PRELOAD: begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            mem_enable = 1'b1;
            mem_size   = SIZE_BYTE;
            mem_addr   = ld_cnt;
            mem_din    = {24'b0, ld_data};
          end
        end
        IDLE: req_ready = 1'b1;
        ACCESS: begin
          mem_enable = 1'b1;
          mem_rw     = req_q.rw;
          mem_size   = req_q.size;
          mem_se     = req_q.se;
          mem_addr   = req_q.addr;
          mem_din    = req_q.wdata;
        end
        RESP: begin
          rsp_valid    = 1'b1;
          rsp_misalign = mis_q;
          rsp_rdata    = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: big-endian RAM model on the mem_* port,
// byte-array reference model for expected responses, randomized requests.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0, ld_last = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready, load_done;
  logic        req_valid = 1'b0, req_rw = 1'b0, req_se = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [8:0]  req_addr = 9'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready, rsp_valid, rsp_misalign;
  logic [31:0] rsp_rdata;
  logic        mem_enable, mem_rw, mem_se;
  logic [1:0]  mem_size;
  logic [8:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  int n_cmp = 0;
  int n_fail = 0;
  int en_count = 0;
  int wr_count = 0;

  logic [7:0] ram [MEM_DEPTH];
  int         ref_mem [MEM_DEPTH];
  logic [7:0] lbuf [600];

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .load_done(load_done),
    .req_valid(req_valid), .req_rw(req_rw), .req_size(req_size), .req_se(req_se),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_size(mem_size), .mem_se(mem_se),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Big-endian RAM: lowest address holds the most significant byte.
  always @(posedge clk) begin
    if (mem_enable) en_count <= en_count + 1;
    if (mem_enable && !mem_rw) begin
      wr_count <= wr_count + 1;
      case (mem_size)
        2'b00: ram[mem_addr] <= mem_din[7:0];
        2'b01: begin
          ram[mem_addr]         <= mem_din[15:8];
          ram[mem_addr + 9'd1]  <= mem_din[7:0];
        end
        default: begin
          ram[mem_addr]         <= mem_din[31:24];
          ram[mem_addr + 9'd1]  <= mem_din[23:16];
          ram[mem_addr + 9'd2]  <= mem_din[15:8];
          ram[mem_addr + 9'd3]  <= mem_din[7:0];
        end
      endcase
    end
  end

  always_comb begin
    case (mem_size)
      2'b00:   mem_dout = {{24{mem_se & ram[mem_addr][7]}}, ram[mem_addr]};
      2'b01:   mem_dout = {{16{mem_se & ram[mem_addr][7]}}, ram[mem_addr], ram[mem_addr + 9'd1]};
      default: mem_dout = {ram[mem_addr], ram[mem_addr + 9'd1], ram[mem_addr + 9'd2], ram[mem_addr + 9'd3]};
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] ref_read(input logic [1:0] size, input logic se, input int addr);
    longint v;
    int n;
    n = 1 << size;
    v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + ref_mem[addr + i];
    if (se && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] size, input int addr);
    return (size == 2'b11) || ((addr % (1 << size)) != 0);
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_bytes(input int n, input logic with_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_data = lbuf[i]; ld_last = with_last && (i == n - 1);
    end
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic run_req(input logic rw, input logic [1:0] size, input logic se,
                         input logic [8:0] addr, input logic [31:0] wdata,
                         output logic rdy, output int lat, output int nvalid,
                         output logic [31:0] rdata, output logic mis, output int nen);
    int en0;
    lat = -1; nvalid = 0; rdata = 32'd0; mis = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = rw; req_size = size; req_se = se;
    req_addr = addr; req_wdata = wdata;
    #1 rdy = req_ready;
    en0 = en_count;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (rsp_valid) begin
        nvalid++;
        if (lat < 0) begin lat = i; rdata = rsp_rdata; mis = rsp_misalign; end
      end
      if (i < 5) @(negedge clk);
    end
    nen = en_count - en0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; ld_valid = 1'b1; ld_data = 8'hA5; req_valid = 1'b1;
    #1;
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ld_ready got=%b exp=0", ld_ready); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready got=%b exp=0", req_ready); end
    n_cmp++; if (mem_enable !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_enable got=%b exp=0", mem_enable); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    @(negedge clk);
    reset = 1'b0; ld_valid = 1'b0; req_valid = 1'b0;
    #1;
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_ld_ready got=%b exp=1", ld_ready); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_load_done got=%b exp=0", load_done); end
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_req_ready got=%b exp=0", req_ready); end
  endtask

  task automatic test_preload_basic();
    logic [7:0] bytes4 [4];
    int wc0;
    bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33; bytes4[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_data = bytes4[i]; ld_last = (i == 3);
      ref_mem[i] = bytes4[i];
      #1;
      n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL preload_ld_ready[%0d] got=%b exp=1", i, ld_ready); end
      n_cmp++; if (mem_enable !== 1'b1 || mem_rw !== 1'b0 || mem_addr !== 9'(i))
        begin n_fail++; $display("[TB] FAIL preload_write[%0d] en=%b rw=%b addr=%0d exp en=1 rw=0 addr=%0d", i, mem_enable, mem_rw, mem_addr, i); end
      n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("[TB] FAIL preload_done_early[%0d] got=%b exp=0", i, load_done); end
    end
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("[TB] FAIL preload_load_done got=%b exp=1", load_done); end
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL preload_req_ready got=%b exp=1", req_ready); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (int'(ram[i]) !== ref_mem[i]) begin n_fail++; $display("[TB] FAIL preload_ram[%0d] got=%h exp=%h", i, ram[i], ref_mem[i]); end
    end
    // Preload bytes outside PRELOAD must be ignored.
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'hEE;
    wc0 = wr_count;
    #1;
    n_cmp++; if (ld_ready !== 1'b0 || mem_enable !== 1'b0)
      begin n_fail++; $display("[TB] FAIL idle_ld_ignored ld_ready=%b mem_enable=%b exp 0 0", ld_ready, mem_enable); end
    @(negedge clk);
    ld_valid = 1'b0;
    n_cmp++; if (wr_count !== wc0) begin n_fail++; $display("[TB] FAIL idle_ld_writes got=%0d exp=%0d", wr_count, wc0); end
  endtask

  task automatic test_word_read();
    logic rdy, mis; int lat, nv, nen; logic [31:0] rd;
    run_req(1'b1, 2'b10, 1'b0, 9'd0, 32'd0, rdy, lat, nv, rd, mis, nen);
    n_cmp++; if (rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL word_read_ready got=%b exp=1", rdy); end
    n_cmp++; if (lat !== 2) begin n_fail++; $display("[TB] FAIL word_read_latency got=%0d exp=2", lat); end
    n_cmp++; if (rd !== ref_read(2'b10, 1'b0, 0)) begin n_fail++; $display("[TB] FAIL word_read_data got=%h exp=%h", rd, ref_read(2'b10, 1'b0, 0)); end
    n_cmp++; if (mis !== 1'b0) begin n_fail++; $display("[TB] FAIL word_read_misalign got=%b exp=0", mis); end
    n_cmp++; if (nv !== 1 || nen !== 1) begin n_fail++; $display("[TB] FAIL word_read_pulses valid=%0d en=%0d exp 1 1", nv, nen); end
  endtask

  task automatic test_misaligned();
    logic rdy, mis; int lat, nv, nen; logic [31:0] rd;
    run_req(1'b0, 2'b10, 1'b0, 9'd2, 32'hDEADBEEF, rdy, lat, nv, rd, mis, nen);
    n_cmp++; if (lat !== 1) begin n_fail++; $display("[TB] FAIL misalign_latency got=%0d exp=1", lat); end
    n_cmp++; if (mis !== 1'b1) begin n_fail++; $display("[TB] FAIL misalign_flag got=%b exp=1", mis); end
    n_cmp++; if (nen !== 0) begin n_fail++; $display("[TB] FAIL misalign_enable got=%0d exp=0", nen); end
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("[TB] FAIL misalign_rdata got=%h exp=0", rd); end
    n_cmp++; if (int'(ram[2]) !== ref_mem[2] || int'(ram[3]) !== ref_mem[3])
      begin n_fail++; $display("[TB] FAIL misalign_ram got=%h%h exp=%h%h", ram[2], ram[3], ref_mem[2][7:0], ref_mem[3][7:0]); end
  endtask

  task automatic test_sign_ext();
    logic rdy, mis; int lat, nv, nen; logic [31:0] rd;
    pulse_reset();
    for (int i = 0; i < 4; i++) lbuf[i] = 8'($urandom);
    lbuf[4] = 8'h80;
    drive_bytes(5, 1'b1);
    for (int i = 0; i < 5; i++) ref_mem[i] = lbuf[i];
    run_req(1'b1, 2'b00, 1'b1, 9'd4, 32'd0, rdy, lat, nv, rd, mis, nen);
    n_cmp++; if (rd !== ref_read(2'b00, 1'b1, 4)) begin n_fail++; $display("[TB] FAIL byte_read_se got=%h exp=%h", rd, ref_read(2'b00, 1'b1, 4)); end
    run_req(1'b1, 2'b00, 1'b0, 9'd4, 32'd0, rdy, lat, nv, rd, mis, nen);
    n_cmp++; if (rd !== ref_read(2'b00, 1'b0, 4)) begin n_fail++; $display("[TB] FAIL byte_read_ze got=%h exp=%h", rd, ref_read(2'b00, 1'b0, 4)); end
  endtask

  task automatic test_stream();
    int wc0;
    pulse_reset();
    for (int i = 0; i < 600; i++) lbuf[i] = 8'($urandom);
    wc0 = wr_count;
    drive_bytes(600, 1'b0);
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = lbuf[i];
    #1;
    n_cmp++; if (wr_count - wc0 !== MEM_DEPTH) begin n_fail++; $display("[TB] FAIL stream_writes got=%0d exp=%0d", wr_count - wc0, MEM_DEPTH); end
    n_cmp++; if (ld_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_ld_ready got=%b exp=0", ld_ready); end
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_load_done got=%b exp=1", load_done); end
  endtask

  task automatic test_random();
    logic rdy, mis, rw, se, emis; int lat, nv, nen, n, addr, bad; logic [31:0] rd, wd, erd;
    logic [1:0] size;
    for (int k = 0; k < 40; k++) begin
      rw = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); addr = $urandom_range(0, MEM_DEPTH - 1);
      wd = $urandom;
      emis = ref_misaligned(size, addr);
      erd = (!emis && rw) ? ref_read(size, se, addr) : 32'd0;
      run_req(rw, size, se, 9'(addr), wd, rdy, lat, nv, rd, mis, nen);
      n_cmp++; if (rdy !== 1'b1 || nv !== 1) begin n_fail++; $display("[TB] FAIL rand[%0d]_handshake ready=%b valid_cnt=%0d exp 1 1", k, rdy, nv); end
      n_cmp++; if (lat !== (emis ? 1 : 2)) begin n_fail++; $display("[TB] FAIL rand[%0d]_latency got=%0d exp=%0d", k, lat, emis ? 1 : 2); end
      n_cmp++; if (mis !== emis) begin n_fail++; $display("[TB] FAIL rand[%0d]_misalign got=%b exp=%b", k, mis, emis); end
      n_cmp++; if (rd !== erd) begin n_fail++; $display("[TB] FAIL rand[%0d]_rdata got=%h exp=%h size=%0d addr=%0d", k, rd, erd, size, addr); end
      n_cmp++; if (nen !== (emis ? 0 : 1)) begin n_fail++; $display("[TB] FAIL rand[%0d]_enable got=%0d exp=%0d", k, nen, emis ? 0 : 1); end
      if (!emis && !rw) begin
        n = 1 << size;
        for (int i = 0; i < n; i++) ref_mem[addr + i] = int'((wd >> (8 * (n - 1 - i))) & 32'hFF);
      end
    end
    bad = 0;
    for (int i = 0; i < MEM_DEPTH; i++) if (int'(ram[i]) !== ref_mem[i]) bad++;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("[TB] FAIL rand_ram_contents bad_bytes=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    int nv;
    nv = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_se = 1'b0; req_addr = 9'd8;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    req_valid = 1'b0;
    n_cmp++; if (nv !== 3) begin n_fail++; $display("[TB] FAIL back_to_back_responses got=%0d exp=3", nv); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_access();
    int nv;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 9'd0;
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (mem_enable !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_in_access got=%b exp=1", mem_enable); end
    reset = 1'b1;
    #1;
    n_cmp++; if (mem_enable !== 1'b0 || rsp_valid !== 1'b0)
      begin n_fail++; $display("[TB] FAIL abort_reset_cycle en=%b rsp_valid=%b exp 0 0", mem_enable, rsp_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (ld_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_ld_ready got=%b exp=1", ld_ready); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_load_done got=%b exp=0", load_done); end
    nv = rsp_valid ? 1 : 0;
    repeat (3) begin @(negedge clk); if (rsp_valid) nv++; end
    n_cmp++; if (nv !== 0) begin n_fail++; $display("[TB] FAIL abort_rsp_valid got=%0d exp=0", nv); end
  endtask

  initial begin
    $display("[TB] starting data_mem_ctrl bench");
    test_reset();
    test_preload_basic();
    test_word_read();
    test_misaligned();
    test_sign_ext();
    test_stream();
    test_random();
    test_back_to_back();
    test_reset_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have one clock, clk, and one synchronous active-high reset, reset; all state changes occur on posedge clk.
REQ-002 Ports (name  direction  width  meaning):
  clk  in  1  system clock
  reset  in  1  synchronous, active-high
  ld_valid  in  1  preload byte present
  ld_data  in  8  preload byte
  ld_last  in  1  final preload byte
  ld_ready  out  1  preload byte accepted this cycle
  load_done  out  1  preload complete, sticky until reset
  req_valid  in  1  pipeline memory request
  req_rw  in  1  1=read, 0=write
  req_size  in  2  00 byte, 01 halfword, 10 word
  req_se  in  1  sign-extend reads
  req_addr  in  9  byte address
  req_wdata  in  32  store data
  req_ready  out  1  request accepted this cycle
  rsp_valid  out  1  one-cycle response strobe
  rsp_rdata  out  32  load data (0 for writes and misaligned requests)
  rsp_misalign  out  1  alignment fault, qualified by rsp_valid
  mem_enable  out  1  RAM Enable
  mem_rw  out  1  RAM ReadWrite
  mem_size  out  2  RAM Size
  mem_se  out  1  RAM SignExtend
  mem_addr  out  9  RAM Address
  mem_din  out  32  RAM DataIn
  mem_dout  in  32  RAM DataOut (combinational read)

Function
REQ-003 SHALL implement states PRELOAD, IDLE, ACCESS and RESP; state after reset is PRELOAD.
REQ-004 PRELOAD: ld_ready=1 and req_ready=0; each ld_valid cycle writes ld_data as a byte (mem_enable=1, mem_rw=0, mem_size=00) to the preload counter address, then increments the counter.
REQ-005 Transition PRELOAD->IDLE on an accepted byte with ld_last=1, or on the byte written at address 511, whichever comes first; load_done goes to 1 on the following cycle.
REQ-006 ld_valid while not in PRELOAD SHALL be ignored (ld_ready=0, no RAM write).
REQ-007 IDLE: req_ready=1; a req_valid cycle latches rw, size, se, addr and wdata.
REQ-008 Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00; size 11 is illegal and treated as misaligned.
REQ-009 Aligned request: IDLE->ACCESS; in ACCESS drive the latched fields for exactly one cycle with mem_enable=1, and capture mem_dout on reads; then ACCESS->RESP.
REQ-010 Misaligned request: IDLE->RESP directly with no mem_enable pulse, and rsp_misalign=1.
REQ-011 RESP: rsp_valid=1 for exactly one cycle, then RESP->IDLE; rsp_rdata holds captured data for reads and 0 otherwise.
REQ-012 Latency: request accepted at edge N; aligned response at N+2; misaligned response at N+1; throughput is one request per 3 cycles (aligned).
REQ-013 mem_enable SHALL be 0 in IDLE and RESP; mem_* outputs other than mem_enable are don't-care when mem_enable=0 and are driven to 0.

Reset
REQ-014 Reset SHALL return state to PRELOAD, clear the preload counter to 0, clear load_done, clear captured data and the request latch, and deassert ld_ready, req_ready, rsp_valid, rsp_misalign and mem_enable in the reset cycle.
REQ-015 Reset asserted during ACCESS or RESP SHALL abort the transaction with no rsp_valid pulse; RAM contents are not cleared.

Structure
REQ-016 State encodings, size codes (BYTE/HALF/WORD) and MEM_DEPTH=512 SHALL live in a shared package used by this block and the RAM bench.
REQ-017 The alignment check SHALL be a sub-module, mem_align_chk (size, addr -> misalign), which is purely combinational.

Verification
REQ-018 Preload bytes 0x11,0x22,0x33,0x44 with ld_last on the 4th byte -> RAM[0..3] = 11 22 33 44, load_done=1 one cycle later, req_ready=1.
REQ-019 After REQ-018: word read at addr 0 -> rsp_valid 2 cycles after acceptance, rsp_rdata=0x11223344, rsp_misalign=0.
REQ-020 Preload 0x80 at addr 4; byte read at addr 4 with se=1 -> rsp_rdata=0xFFFFFF80; with se=0 -> rsp_rdata=0x00000080.
REQ-021 Word write at addr 2 -> rsp_valid 1 cycle after acceptance, rsp_misalign=1, no mem_enable pulse; RAM unchanged.
REQ-022 Stream 600 bytes without ld_last -> exactly 512 writes, then ld_ready=0 and load_done=1.
REQ-023 Assert reset during ACCESS -> no rsp_valid; state returns to PRELOAD with load_done=0 and ld_ready=1 on the next cycle.
